// File: rtl/sc_mon_pkg.sv
// ---------------------------------------------------------------------------
// sc_mon_pkg
// Shared types and defaults for the self-composition timing monitor.
//   mon_state_t : monitor FSM states (IDLE, RUN, DONE)
//   CNT_W       : default latency counter width
//   MAX_CYCLES  : default timeout bound in cycles after start
//   absdiff     : unsigned absolute difference of two values
// ---------------------------------------------------------------------------
package sc_mon_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mon_state_t;

  localparam int CNT_W      = 16;
  localparam int MAX_CYCLES = 16'hFFF0;

  // Operands are widened to 32 bits so callers with any CNT_W up to 32 can
  // reuse the function and truncate the result to their own width.
  function automatic logic [31:0] absdiff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/finish_latch.sv
// ---------------------------------------------------------------------------
// finish_latch
// Captures the first rising of one RSA copy's finish level during a run.
// Holds the capture flag, the latency and the decrypted result.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clear           : start of a new run, drops any previous capture
//   en              : capture window open (monitor is in RUN)
//   finish          : completion level from the RSA copy
//   cnt             : monitor cycle counter value before this edge
//   data            : decrypted result from the RSA copy
//   got             : a finish has been captured this run
//   cycles          : latched latency (cnt + 1 at the capture edge)
//   result          : latched decrypted result
// ---------------------------------------------------------------------------
module finish_latch #(
  parameter int CNT_W = 16,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             finish,
  input  logic [CNT_W-1:0] cnt,
  input  logic [DW-1:0]    data,
  output logic             got,
  output logic [CNT_W-1:0] cycles,
  output logic [DW-1:0]    result
);

  // Only the first edge of a finish level counts; the level may stay high
  // for the rest of the run and must not overwrite the latency.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      got    <= 1'b0;
      cycles <= '0;
      result <= '0;
    end else if (en && finish && !got) begin
      got    <= 1'b1;
      cycles <= cnt + CNT_W'(1);
      result <= data;
    end
  end

endmodule

// File: rtl/sc_timing_monitor.sv
// ---------------------------------------------------------------------------
// sc_timing_monitor
// Verdict stage of the two-copy RSA timing experiment. Measures each copy's
// latency from KeyGenStart and flags a timing leak when they differ; runs
// with a violated prime assumption are reported as vacuous.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   KeyGenStart                  : run start shared with both RSA copies
//   assume_ok[3:0]               : AssumePrime bits {q_2, p_2, q_1, p_1}
//   finish_1, finish_2           : completion levels of the two copies
//   m_decrypted_1, m_decrypted_2 : decrypted results of the two copies
//   busy                         : run in progress
//   done                         : one-cycle verdict pulse
//   cycles_1, cycles_2           : latched latencies
//   delta                        : |cycles_1 - cycles_2|
//   run_leak                     : leak verdict of the last run
//   leak                         : sticky OR of run_leak since reset
//   timeout                      : last run hit MAX_CYCLES
//   vacuous                      : last run had an assumption violated
//   data_mismatch                : results of the last run differ
// ---------------------------------------------------------------------------
module sc_timing_monitor #(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = sc_mon_pkg::CNT_W,
  parameter int MAX_CYCLES = sc_mon_pkg::MAX_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               KeyGenStart,
  input  logic [3:0]         assume_ok,
  input  logic               finish_1,
  input  logic               finish_2,
  input  logic [2*WIDTH-1:0] m_decrypted_1,
  input  logic [2*WIDTH-1:0] m_decrypted_2,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cycles_1,
  output logic [CNT_W-1:0]   cycles_2,
  output logic [CNT_W-1:0]   delta,
  output logic               run_leak,
  output logic               leak,
  output logic               timeout,
  output logic               vacuous,
  output logic               data_mismatch
);

  import sc_mon_pkg::*;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

  mon_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_inc;
  logic               vac_q, timeout_q, verdict_q, done_q, leak_q;
  logic               in_run, start_run, hit_max, both_next, run_exit;
  logic               got_1, got_2, run_leak_raw;
  logic [2*WIDTH-1:0] res_1, res_2;

  assign in_run    = (state_q == RUN);
  assign start_run = KeyGenStart && !in_run;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign hit_max   = in_run && (cnt_inc == MAX_C);

  // Looks ahead at this edge's captures so the run can end on the very
  // cycle the second copy finishes.
  assign both_next = (got_1 || finish_1) && (got_2 || finish_2);
  assign run_exit  = in_run && (both_next || hit_max);

  finish_latch #(.CNT_W(CNT_W), .DW(2*WIDTH)) u_latch_1 (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_run),
    .en     (in_run),
    .finish (finish_1),
    .cnt    (cnt_q),
    .data   (m_decrypted_1),
    .got    (got_1),
    .cycles (cycles_1),
    .result (res_1)
  );

  finish_latch #(.CNT_W(CNT_W), .DW(2*WIDTH)) u_latch_2 (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_run),
    .en     (in_run),
    .finish (finish_2),
    .cnt    (cnt_q),
    .data   (m_decrypted_2),
    .got    (got_2),
    .cycles (cycles_2),
    .result (res_2)
  );

  // Next-state logic: a start is honoured from IDLE or DONE, never in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (KeyGenStart) state_d = RUN;
      RUN:     if (run_exit)    state_d = DONE;
      DONE:    if (KeyGenStart) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // State register, saturating counter and per-run flags. verdict_q marks
  // that the latched values describe a finished run and may be reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      vac_q     <= 1'b0;
      timeout_q <= 1'b0;
      verdict_q <= 1'b0;
      done_q    <= 1'b0;
      leak_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= run_exit;
      if (state_q == DONE) leak_q <= leak_q | run_leak;
      if (start_run) begin
        cnt_q     <= '0;
        vac_q     <= ~&assume_ok;
        timeout_q <= 1'b0;
        verdict_q <= 1'b0;
      end else if (in_run) begin
        if (cnt_q != '1) cnt_q <= cnt_inc;
        if (!(&assume_ok)) vac_q <= 1'b1;
        if (run_exit) begin
          verdict_q <= 1'b1;
          timeout_q <= hit_max;
        end
      end
    end
  end

  // Verdict outputs are derived from latched state and only shown once the
  // run has ended; the latches are frozen in DONE so the values hold.
  // An absent copy has cycles = 0, so delta naturally counts it as 0.
  assign run_leak_raw  = !vac_q && ((got_1 != got_2) || (cycles_1 != cycles_2));
  assign run_leak      = verdict_q && run_leak_raw;
  assign leak          = leak_q || run_leak;
  assign busy          = in_run;
  assign done          = done_q;
  assign timeout       = verdict_q && timeout_q;
  assign vacuous       = verdict_q && vac_q;
  assign data_mismatch = verdict_q && got_1 && got_2 && !vac_q && (res_1 != res_2);
  assign delta         = verdict_q ? CNT_W'(absdiff(32'(cycles_1), 32'(cycles_2))) : '0;

endmodule

// File: tb/tb_sc_timing_monitor.sv
// ---------------------------------------------------------------------------
// tb_sc_timing_monitor
// Directed runs of the timing monitor with hand-computed verdicts. Each run
// pushes its expected verdict into a queue; an independent monitor pops and
// compares whenever done pulses.
// ---------------------------------------------------------------------------
module tb_sc_timing_monitor;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  typedef struct {
    int c1;
    int c2;
    int dl;
    int rl;
    int lk;
    int to;
    int vac;
    int dm;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               KeyGenStart = 1'b0;
  logic [3:0]         assume_ok = 4'hF;
  logic               finish_1 = 1'b0;
  logic               finish_2 = 1'b0;
  logic [2*WIDTH-1:0] m_decrypted_1 = '0;
  logic [2*WIDTH-1:0] m_decrypted_2 = '0;
  logic               busy, done, run_leak, leak, timeout, vacuous, data_mismatch;
  logic [CNT_W-1:0]   cycles_1, cycles_2, delta;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  sc_timing_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_CYCLES(100)) dut (
    .clk           (clk),
    .rst           (rst),
    .KeyGenStart   (KeyGenStart),
    .assume_ok     (assume_ok),
    .finish_1      (finish_1),
    .finish_2      (finish_2),
    .m_decrypted_1 (m_decrypted_1),
    .m_decrypted_2 (m_decrypted_2),
    .busy          (busy),
    .done          (done),
    .cycles_1      (cycles_1),
    .cycles_2      (cycles_2),
    .delta         (delta),
    .run_leak      (run_leak),
    .leak          (leak),
    .timeout       (timeout),
    .vacuous       (vacuous),
    .data_mismatch (data_mismatch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    chk("cycles_1", 32'(cycles_1), e.c1);
    chk("cycles_2", 32'(cycles_2), e.c2);
    chk("delta", 32'(delta), e.dl);
    chk("run_leak", 32'(run_leak), e.rl);
    chk("leak", 32'(leak), e.lk);
    chk("timeout", 32'(timeout), e.to);
    chk("vacuous", 32'(vacuous), e.vac);
    chk("data_mismatch", 32'(data_mismatch), e.dm);
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_cycles_1"}, 32'(cycles_1), 0);
    chk({tag, "_cycles_2"}, 32'(cycles_2), 0);
    chk({tag, "_delta"}, 32'(delta), 0);
    chk({tag, "_run_leak"}, 32'(run_leak), 0);
    chk({tag, "_leak"}, 32'(leak), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_vacuous"}, 32'(vacuous), 0);
    chk({tag, "_data_mismatch"}, 32'(data_mismatch), 0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no verdict pending");
      end else begin
        checkOutput(exp_q.pop_front());
      end
    end
  end

  // One run: finishes rise at edge number f1/f2 after the start edge
  // (0 = never), an optional stray start at edge xs, then wait for done.
  task automatic applyStimulus(input string name, input logic [3:0] ok,
                               input int f1, input int f2,
                               input logic [15:0] d1, input logic [15:0] d2,
                               input int xs, input exp_t e);
    bit seen = 1'b0;
    @(negedge clk);
    assume_ok     = ok;
    m_decrypted_1 = d1;
    m_decrypted_2 = d2;
    KeyGenStart   = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    KeyGenStart = 1'b0;
    chk({name, "_busy_start"}, 32'(busy), 1);
    for (int k = 1; k <= 200; k++) begin
      finish_1    = (f1 != 0) && (k >= f1);
      finish_2    = (f2 != 0) && (k >= f2);
      KeyGenStart = (k == xs);
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_done_seen"}, 32'(seen), 1);
    chk({name, "_busy_end"}, 32'(busy), 0);
    @(negedge clk);
    finish_1    = 1'b0;
    finish_2    = 1'b0;
    KeyGenStart = 1'b0;
    assume_ok   = 4'hF;
  endtask

  initial begin
    exp_t e;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    e = '{c1: 40, c2: 40, dl: 0, rl: 0, lk: 0, to: 0, vac: 0, dm: 0};
    applyStimulus("equal", 4'hF, 40, 40, 16'h1234, 16'h1234, 0, e);

    e = '{c1: 10, c2: 18, dl: 8, rl: 0, lk: 0, to: 0, vac: 1, dm: 0};
    applyStimulus("vacuous", 4'b1110, 10, 18, 16'h1234, 16'h1234, 0, e);

    e = '{c1: 37, c2: 52, dl: 15, rl: 1, lk: 1, to: 0, vac: 0, dm: 0};
    applyStimulus("skew", 4'hF, 37, 52, 16'h1234, 16'h1234, 0, e);

    e = '{c1: 25, c2: 25, dl: 0, rl: 0, lk: 1, to: 0, vac: 0, dm: 0};
    applyStimulus("clean", 4'hF, 25, 25, 16'h5555, 16'h5555, 0, e);

    e = '{c1: 30, c2: 0, dl: 30, rl: 1, lk: 1, to: 1, vac: 0, dm: 0};
    applyStimulus("timeout", 4'hF, 30, 0, 16'h0001, 16'h0001, 0, e);

    e = '{c1: 20, c2: 20, dl: 0, rl: 0, lk: 1, to: 0, vac: 0, dm: 1};
    applyStimulus("mismatch", 4'hF, 20, 20, 16'h00AB, 16'h00AC, 10, e);

    // Reset asserted for edge 15 of a run that never finishes.
    @(negedge clk);
    KeyGenStart = 1'b1;
    @(negedge clk);
    KeyGenStart = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midreset_busy_after", 32'(busy), 0);
    chk("pending_verdicts", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_timing_monitor.md
# sc_timing_monitor

Downstream checker for the two-copy RSA self-composition: it watches `finish_1`/`finish_2` and `m_decrypted_1`/`m_decrypted_2` of both copies, which run on the same message `m` but use different secret primes. It measures each copy's latency from `KeyGenStart` and reports a timing leak when the latencies differ. Runs where the prime assumptions are violated are marked vacuous. It is the verdict stage of the timing side-channel experiment.

## Interface

Parameters:
- `WIDTH`, 8: prime width; message and result width is `2*WIDTH`.
- `CNT_W`, 16: cycle counter width.
- `MAX_CYCLES`, 16'hFFF0: timeout bound in cycles after start; must be less than 2^CNT_W-1.

Ports:
- One clock; reset is synchronous and active-high.
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `KeyGenStart` in 1: run start, the same signal that drives both RSA copies.
- `assume_ok` in 4: AssumePrime bits {q_2, p_2, q_1, p_1}.
- `finish_1`, `finish_2` in 1 each: completion levels from the two RSA copies.
- `m_decrypted_1`, `m_decrypted_2` in `2*WIDTH` each: decrypted results.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle verdict pulse.
- `cycles_1`, `cycles_2` out `CNT_W` each: latched latencies.
- `delta` out `CNT_W`: |cycles_1 - cycles_2|.
- `run_leak` out 1: verdict for the last run.
- `leak` out 1: sticky OR of all `run_leak` since reset.
- `timeout` out 1: last run hit `MAX_CYCLES`.
- `vacuous` out 1: last run had an assumption violated.
- `data_mismatch` out 1: results of the last run differ.

## Operation

- FSM states: IDLE, RUN, DONE.
- **IDLE or DONE, `KeyGenStart`=1**: go to RUN.
  - Clear `cnt`, `cycles_*`, `got_1`, `got_2` and all per-run flags.
  - Set `vac` = ~&`assume_ok`.
- **RUN, counting**: `cnt` increments every cycle and saturates at all-ones.
- **RUN, assumptions**: if any `assume_ok` bit is 0 on any cycle, set `vac`.
- **RUN, finish capture**: on the first cycle `finish_k`=1 with `got_k`=0:
  - `cycles_k` <= `cnt`+1, so `cycles_k` = number of clock edges from the start sample to the finish sample.
  - Capture `m_decrypted_k`.
  - Set `got_k`.
  - Later cycles of a `finish_k` level are ignored.
- **RUN, exit**: go to DONE when both `got` bits are set (including the cycle the second one sets), or when `cnt`+1 = `MAX_CYCLES` (sets `timeout`).
- **RUN to DONE transition**: pulse `done` on the DONE entry cycle and update the verdict outputs:
  - `run_leak` = ~`vac` & (`got_1` != `got_2` | `cycles_1` != `cycles_2`).
  - `data_mismatch` = both `got` bits set & ~`vac` & captured results differ.
  - `delta` computed from the latched values; an absent copy counts as 0.
  - `leak` |= `run_leak`.
- **DONE**: hold all outputs until the next start.
- **`KeyGenStart` during RUN**: ignored.
- **Simultaneous finishes** in one cycle: both captured, `delta`=0.
- **Finish already high on the start cycle**: not captured. Capture needs `finish_k` high in RUN.

## Timing

- Reset value of every output is 0, and the FSM resets to IDLE.
- Reset mid-run aborts the run with no `done`, and clears `leak`.
- `busy`=1 exactly while in RUN, starting the cycle after `KeyGenStart` is sampled.
- Verdict latency: `done` is asserted the cycle after the last capture or timeout condition. Verdict outputs are valid in that same cycle.
- Back-to-back runs: a start sampled in DONE is legal. That DONE cycle is still the `done` cycle of the previous run only if it is the entry cycle.
- No throughput requirement beyond one run in flight.

## Structure

- Package `sc_mon_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} mon_state_t`
  - the default constants `CNT_W` and `MAX_CYCLES`
  - a function `absdiff`.
- Sub-module `finish_latch`, instantiated twice (one per copy). It holds `got`, `cycles` and the captured result. Inputs are `clear`, `en`, `finish`, `cnt` and data. The FSM, counter and verdict logic live in the top.

## Test plan

- **Equal latency**: start, assumptions 4'hF, both finishes at cycle 40 with results 16'h1234 -> `done` at cycle 41, `cycles_1`=`cycles_2`=40, `delta`=0, `run_leak`=0, `leak`=0.
- **Skewed latency**: `finish_1` at 37, `finish_2` at 52 -> `delta`=15, `run_leak`=1. `leak` stays 1 across a following clean run.
- **Vacuous run**: `assume_ok`=4'b1110 at start, skewed finishes -> `vacuous`=1, `run_leak`=0, `leak` unchanged.
- **Timeout**: `MAX_CYCLES`=100, only `finish_1` at 30 -> `done` after cycle 100, `timeout`=1, `run_leak`=1, `cycles_2`=0, `delta`=30.
- **Data mismatch and start in RUN**: equal finishes at 20, results 16'h00AB vs 16'h00AC -> `data_mismatch`=1, `run_leak`=0. A `KeyGenStart` pulse at cycle 10 of that run does not reset `cnt`.
- **Reset mid-run**: `rst` at cycle 15 -> all outputs 0 next cycle, `busy`=0, no `done` pulse.
